// File: rtl/decode_register_scoreboard.sv
// Per-register in-flight write/load tracking; pending/hazard flags are combinational from registered state.
// issue_ready drops on load-use hazard, counter saturation or flush; counters update on the next rising edge.
module decode_register_scoreboard #(
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 2,
  parameter int PERF_WIDTH     = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs1,
  input  logic                      issue_rs1_en,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs2,
  input  logic                      issue_rs2_en,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic                      issue_rd_we,
  input  logic                      issue_is_load,
  input  logic                      ldc_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ldc_rd,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      flush,
  output logic                      rs1_pending,
  output logic                      rs2_pending,
  output logic [PERF_WIDTH-1:0]     stall_cycles,
  output logic                      err_underflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Entry 0 exists only to keep indexing simple; no event ever targets it.
  logic [CNT_WIDTH-1:0] wr_cnt     [NUM_REGS];
  logic [CNT_WIDTH-1:0] ld_cnt     [NUM_REGS];
  logic [CNT_WIDTH-1:0] wr_cnt_nxt [NUM_REGS];
  logic [CNT_WIDTH-1:0] ld_cnt_nxt [NUM_REGS];

  logic [NUM_REGS-1:0] wr_inc, wr_dec, ld_inc, ld_dec;
  logic                haz1, haz2, sat, fire, uflow;

  assign rs1_pending = issue_rs1_en && (issue_rs1 != '0) && (wr_cnt[issue_rs1] != '0);
  assign rs2_pending = issue_rs2_en && (issue_rs2 != '0) && (wr_cnt[issue_rs2] != '0);
  assign haz1        = issue_rs1_en && (issue_rs1 != '0) && (ld_cnt[issue_rs1] != '0);
  assign haz2        = issue_rs2_en && (issue_rs2 != '0) && (ld_cnt[issue_rs2] != '0);
  assign sat         = issue_rd_we && (issue_rd != '0) && (wr_cnt[issue_rd] == CNT_MAX);
  assign issue_ready = !haz1 && !haz2 && !sat && !flush;
  assign fire        = issue_valid && issue_ready;

  // One-hot event vectors; flush discards completions as well as issue.
  assign wr_inc = (fire && issue_rd_we && issue_rd != '0) ? (NUM_REGS'(1) << issue_rd) : '0;
  assign ld_inc = (fire && issue_rd_we && issue_is_load && issue_rd != '0) ?
                  (NUM_REGS'(1) << issue_rd) : '0;
  assign wr_dec = (wb_valid && !flush && wb_rd != '0) ? (NUM_REGS'(1) << wb_rd) : '0;
  assign ld_dec = (ldc_valid && !flush && ldc_rd != '0) ? (NUM_REGS'(1) << ldc_rd) : '0;

  always_comb begin
    uflow = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_cnt_nxt[r] = wr_cnt[r];
      ld_cnt_nxt[r] = ld_cnt[r];
      if (wr_inc[r] && !wr_dec[r]) begin
        wr_cnt_nxt[r] = wr_cnt[r] + 1'b1;
      end else if (wr_dec[r] && !wr_inc[r]) begin
        if (wr_cnt[r] == '0) uflow = 1'b1;
        else                 wr_cnt_nxt[r] = wr_cnt[r] - 1'b1;
      end
      if (ld_inc[r] && !ld_dec[r]) begin
        ld_cnt_nxt[r] = ld_cnt[r] + 1'b1;
      end else if (ld_dec[r] && !ld_inc[r]) begin
        if (ld_cnt[r] == '0) uflow = 1'b1;
        else                 ld_cnt_nxt[r] = ld_cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        wr_cnt[r] <= '0;
        ld_cnt[r] <= '0;
      end
      stall_cycles  <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        wr_cnt[r] <= flush ? '0 : wr_cnt_nxt[r];
        ld_cnt[r] <= flush ? '0 : ld_cnt_nxt[r];
      end
      if (issue_valid && !issue_ready && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (uflow)
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_register_scoreboard.sv
// Randomized + directed bench for decode_register_scoreboard with a counting reference model and output scoreboard.
module tb_decode_register_scoreboard;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 0, issue_rs1_en = 0, issue_rs2_en = 0, issue_rd_we = 0, issue_is_load = 0;
  logic [4:0]  issue_rs1 = 0, issue_rs2 = 0, issue_rd = 0, ldc_rd = 0, wb_rd = 0;
  logic        ldc_valid = 0, wb_valid = 0, flush = 0;
  logic        issue_ready, rs1_pending, rs2_pending, err_underflow;
  logic [31:0] stall_cycles;

  decode_register_scoreboard dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs1_en(issue_rs1_en),
    .issue_rs2(issue_rs2), .issue_rs2_en(issue_rs2_en),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_is_load(issue_is_load),
    .ldc_valid(ldc_valid), .ldc_rd(ldc_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .stall_cycles(stall_cycles), .err_underflow(err_underflow)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic v; logic [4:0] rs1; logic e1; logic [4:0] rs2; logic e2;
    logic [4:0] rd; logic we; logic ld;
    logic lv; logic [4:0] lrd; logic wv; logic [4:0] wrd; logic fl;
  } stim_t;

  typedef struct packed {
    logic ready; logic p1; logic p2; logic [31:0] stall; logic err;
  } exp_t;

  // Reference model: outstanding producers per register as plain integers.
  int          wcnt [32];
  int          lcnt [32];
  logic [31:0] stall_m;
  logic        err_m;
  exp_t        expq [$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      wcnt[r] = 0;
      lcnt[r] = 0;
    end
    stall_m = 0;
    err_m   = 0;
  endtask

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    bit h1, h2, st;
    h1 = s.e1 && s.rs1 != 0 && lcnt[s.rs1] > 0;
    h2 = s.e2 && s.rs2 != 0 && lcnt[s.rs2] > 0;
    st = s.we && s.rd != 0 && wcnt[s.rd] >= 3;
    e.ready = !h1 && !h2 && !st && !s.fl;
    e.p1    = s.e1 && s.rs1 != 0 && wcnt[s.rs1] > 0;
    e.p2    = s.e2 && s.rs2 != 0 && wcnt[s.rs2] > 0;
    e.stall = stall_m;
    e.err   = err_m;
    return e;
  endfunction

  // Issue is applied before completions, so a same-cycle issue+retire on one register nets to zero.
  task automatic model_step(input stim_t s, input logic rdy);
    if (s.v && !rdy && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 1;
    if (s.fl) begin
      for (int r = 0; r < 32; r++) begin
        wcnt[r] = 0;
        lcnt[r] = 0;
      end
    end else begin
      if (s.v && rdy && s.we && s.rd != 0) begin
        wcnt[s.rd]++;
        if (s.ld) lcnt[s.rd]++;
      end
      if (s.lv && s.lrd != 0) begin
        if (lcnt[s.lrd] == 0) err_m = 1;
        else lcnt[s.lrd]--;
      end
      if (s.wv && s.wrd != 0) begin
        if (wcnt[s.wrd] == 0) err_m = 1;
        else wcnt[s.wrd]--;
      end
    end
  endtask

  // Called at posedge+1: drive, predict, then advance the model at the next edge.
  task automatic cycle(input stim_t s);
    exp_t e;
    issue_valid = s.v; issue_rs1 = s.rs1; issue_rs1_en = s.e1;
    issue_rs2 = s.rs2; issue_rs2_en = s.e2; issue_rd = s.rd;
    issue_rd_we = s.we; issue_is_load = s.ld;
    ldc_valid = s.lv; ldc_rd = s.lrd; wb_valid = s.wv; wb_rd = s.wrd; flush = s.fl;
    e = predict(s);
    expq.push_back(e);
    @(posedge clock);
    model_step(s, e.ready);
    #1;
  endtask

  function automatic stim_t st(input bit v, input int rs1, input bit e1, input int rs2, input bit e2,
                               input int rd, input bit we, input bit ld, input bit lv, input int lrd,
                               input bit wv, input int wrd, input bit fl);
    stim_t s;
    s.v = v; s.rs1 = 5'(rs1); s.e1 = e1; s.rs2 = 5'(rs2); s.e2 = e2;
    s.rd = 5'(rd); s.we = we; s.ld = ld; s.lv = lv; s.lrd = 5'(lrd);
    s.wv = wv; s.wrd = 5'(wrd); s.fl = fl;
    return s;
  endfunction

  // Monitor: every cycle the DUT presents a fresh output set; compare mid-cycle.
  always @(negedge clock) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("issue_ready", 32'(issue_ready), 32'(e.ready));
      chk("rs1_pending", 32'(rs1_pending), 32'(e.p1));
      chk("rs2_pending", 32'(rs2_pending), 32'(e.p2));
      chk("stall_cycles", stall_cycles, e.stall);
      chk("err_underflow", 32'(err_underflow), 32'(e.err));
    end
  end

  stim_t dir [$];

  initial begin
    stim_t s;
    int    r;
    model_reset();
    #2;
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_rs1_pending", 32'(rs1_pending), 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    chk("rst_err_underflow", 32'(err_underflow), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Load-use on r5, then retire; ALU producer r7; saturation on r3; cancel on r9; r0 ignored.
    dir.push_back(st(1,0,0,0,0, 5,1,1, 0,0, 0,0, 0));
    dir.push_back(st(1,5,1,0,0, 6,1,0, 0,0, 0,0, 0));
    dir.push_back(st(1,5,1,0,0, 6,1,0, 1,5, 0,0, 0));
    dir.push_back(st(1,5,1,0,0, 6,1,0, 0,0, 0,0, 0));
    dir.push_back(st(0,5,1,0,0, 0,0,0, 0,0, 1,5, 0));
    dir.push_back(st(1,0,0,0,0, 7,1,0, 0,0, 1,6, 0));
    dir.push_back(st(1,0,0,7,1, 0,0,0, 0,0, 1,7, 0));
    dir.push_back(st(1,5,1,7,1, 0,0,0, 0,0, 0,0, 0));
    for (int i = 0; i < 3; i++) dir.push_back(st(1,0,0,0,0, 3,1,0, 0,0, 0,0, 0));
    dir.push_back(st(1,0,0,0,0, 3,1,0, 0,0, 0,0, 0));
    dir.push_back(st(1,0,0,0,0, 3,1,0, 0,0, 1,3, 0));
    dir.push_back(st(1,3,1,0,0, 3,1,0, 0,0, 0,0, 0));
    for (int i = 0; i < 3; i++) dir.push_back(st(0,0,0,0,0, 0,0,0, 0,0, 1,3, 0));
    dir.push_back(st(1,0,0,0,0, 9,1,0, 0,0, 1,3, 0));
    dir.push_back(st(1,9,1,0,0, 9,1,0, 0,0, 1,9, 0));
    dir.push_back(st(1,9,1,0,0, 0,0,0, 0,0, 1,9, 0));
    dir.push_back(st(1,0,1,0,1, 0,1,1, 1,0, 1,0, 0));
    dir.push_back(st(0,0,0,0,0, 0,0,0, 0,0, 1,12, 0));
    dir.push_back(st(0,0,0,0,0, 0,0,0, 0,0, 0,0, 0));
    // Flush with several loads pending and an issue presented in the flush cycle.
    dir.push_back(st(1,0,0,0,0, 10,1,1, 0,0, 0,0, 0));
    dir.push_back(st(1,0,0,0,0, 11,1,1, 0,0, 0,0, 0));
    dir.push_back(st(1,10,1,11,1, 13,1,0, 0,0, 0,0, 0));
    dir.push_back(st(1,10,1,11,1, 13,1,0, 1,10, 1,11, 1));
    dir.push_back(st(1,10,1,11,1, 0,0,0, 0,0, 0,0, 0));
    dir.push_back(st(1,0,0,0,0, 14,1,1, 0,0, 0,0, 0));
    dir.push_back(st(1,14,1,0,0, 0,0,0, 0,0, 0,0, 0));
    dir.push_back(st(1,14,1,0,0, 0,0,0, 0,0, 0,0, 0));
    foreach (dir[i]) cycle(dir[i]);

    // Asynchronous reset while stalled: state must read zero before any edge.
    reset = 1'b0;
    #1;
    chk("arst_issue_ready", 32'(issue_ready), 32'd1);
    chk("arst_rs1_pending", 32'(rs1_pending), 32'd0);
    chk("arst_stall_cycles", stall_cycles, 32'd0);
    chk("arst_err_underflow", 32'(err_underflow), 32'd0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b1;

    // Random traffic; completions only target registers with a matching outstanding producer.
    for (int n = 0; n < 3000; n++) begin
      s.v   = ($urandom_range(0, 9) < 8);
      s.rs1 = 5'($urandom_range(0, 7)); s.e1 = 1'($urandom_range(0, 1));
      s.rs2 = 5'($urandom_range(0, 7)); s.e2 = 1'($urandom_range(0, 1));
      s.rd  = 5'($urandom_range(0, 7)); s.we = ($urandom_range(0, 3) != 0);
      s.ld  = ($urandom_range(0, 2) == 0);
      r     = $urandom_range(1, 7);
      s.lrd = 5'(r); s.lv = (lcnt[r] > 0) && ($urandom_range(0, 2) == 0);
      r     = $urandom_range(1, 7);
      s.wrd = 5'(r); s.wv = (wcnt[r] > lcnt[r]) && ($urandom_range(0, 2) == 0);
      s.fl  = ($urandom_range(0, 39) == 0);
      cycle(s);
    end

    @(negedge clock); #1;
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
